ltl_report_collector: RTL
=========================

Name: ltl_report_collector

Overview:
- Sits directly downstream of a cluster automaton (the Automata_ltl* monitors) and consumes its per-cycle report vector, e.g. the four active-state report outputs of an LTL cluster.
- Timestamps each cycle carrying at least one report with the symbol index and queues it in a small show-ahead FIFO for the monitor readout logic.
- Keeps per-report sticky flags, saturating hit counters and a dropped-event counter.

Parameters:
- NUM_REPORTS, 4, width of the report vector consumed from the automaton.
- TS_WIDTH, 32, symbol-index timestamp width; wraps modulo 2^TS_WIDTH.
- FIFO_DEPTH, 8, event queue depth; must be a power of two and at least 2.
- CNT_WIDTH, 16, width of each per-report hit counter and of the drop counter.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- run  input  1  symbol-valid strobe, the same run that drives the automaton; report_in is sampled only when run=1.
- report_in  input  NUM_REPORTS  report/active-state outputs of the automaton, bit i = report i.
- clear  input  1  synchronous soft clear of all state; same effect as reset.
- ev_valid  output  1  FIFO non-empty; head entry presented.
- ev_ready  input  1  consumer accepts the head entry when ev_valid&&ev_ready.
- ev_vector  output  NUM_REPORTS  report vector of the head entry.
- ev_timestamp  output  TS_WIDTH  symbol index of the head entry.
- fifo_level  output  $clog2(FIFO_DEPTH)+1  current occupancy, 0..FIFO_DEPTH.
- sticky_flags  output  NUM_REPORTS  bit i set once report i is seen; cleared only by reset/clear.
- hit_count  output  NUM_REPORTS*CNT_WIDTH  saturating per-report counts, report i at slice [i*CNT_WIDTH +: CNT_WIDTH].
- drop_count  output  CNT_WIDTH  saturating count of events lost to a full FIFO.
- overflow  output  1  sticky; set on the first drop.
- any_report  output  1  registered pulse, one cycle after a sampled cycle with nonzero report_in; interrupt source.

Behaviour:
- Reset/clear: all outputs 0, FIFO empty, symbol index 0. clear has priority over everything in the same cycle: that cycle's report, push and pop are all discarded.
- Symbol index: sym_idx increments by 1 on every run=1 cycle and wraps silently. The timestamp of a sampled cycle is sym_idx before the increment, so the first run cycle after reset gets timestamp 0.
- Event: run=1 and report_in!=0.
  - Push {report_in, sym_idx}.
  - Set sticky_flags |= report_in.
  - Increment hit_count[i] for each set bit i; each counter holds at 2^CNT_WIDTH-1.
  - any_report=1 in the next cycle.
- run=0: report_in is ignored and nothing is updated.
- report_in=0 with run=1: sym_idx advances; nothing is pushed.
- FIFO is show-ahead. The head is visible on ev_vector/ev_timestamp whenever ev_valid=1. When ev_valid=0 the contents are don't-care but must be stable.
- Push at edge t: ev_valid and fifo_level reflect it immediately after edge t (1-cycle latency).
- Pop occurs when ev_valid&&ev_ready. The next entry, if any, is presented after the same edge.
- Simultaneous push and pop:
  - Both occur and fifo_level is unchanged.
  - This holds even when full: push is accepted when a pop occurs in the same cycle.
  - When empty, no pop occurs (ev_valid=0), so the push alone lands.
- Full (level=FIFO_DEPTH) with an event and no pop in the same cycle:
  - The event is dropped.
  - drop_count increments (saturating) and overflow is set.
  - Sticky flags and hit counters still update.
  - The FIFO contents are untouched.
- Pointers are $clog2(FIFO_DEPTH) bits and wrap naturally. Level arithmetic does not overflow at full.
- All outputs are driven from registers; there is no combinational path from inputs to outputs.

Test Plan:
- Reset, then 5 run cycles with report_in=0, then report_in=4'b0101 with run=1 -> the cycle after: ev_valid=1, ev_vector=0101, ev_timestamp=5, fifo_level=1, sticky=0101, hit_count[0]=hit_count[2]=1, any_report pulses for 1 cycle.
- ev_ready=0; 10 consecutive run cycles, each with report_in=4'b0010 -> fifo_level=8, drop_count=2, overflow=1, hit_count[1]=10; popping all 8 yields timestamps 0..7 in order.
- FIFO full, event arrives in the same cycle as ev_ready=1 -> level stays 8, drop_count unchanged, the new entry lands at the tail.
- run=0 with report_in=4'b1111 for 3 cycles -> no push, sym_idx unchanged, counters unchanged.
- Assert clear with 3 entries queued and an event in the same cycle -> next cycle all outputs 0, ev_valid=0; the next run event gets timestamp 0.
- Force sym_idx near 2^TS_WIDTH-1 (TS_WIDTH=4 build) and run 18 event cycles -> timestamps wrap 15->0. With CNT_WIDTH=4, hit_count saturates at 15.

Source files
------------

// File: rtl/ltl_report_collector.sv
// Report collector for an LTL cluster automaton: timestamps reporting
// cycles into a show-ahead event FIFO and keeps sticky/hit/drop statistics.
module ltl_report_collector #(
    parameter int NUM_REPORTS = 4,
    parameter int TS_WIDTH    = 32,
    parameter int FIFO_DEPTH  = 8,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            run,
    input  logic [NUM_REPORTS-1:0]          report_in,
    input  logic                            clear,
    output logic                            ev_valid,
    input  logic                            ev_ready,
    output logic [NUM_REPORTS-1:0]          ev_vector,
    output logic [TS_WIDTH-1:0]             ev_timestamp,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
    output logic [NUM_REPORTS-1:0]          sticky_flags,
    output logic [NUM_REPORTS*CNT_WIDTH-1:0] hit_count,
    output logic [CNT_WIDTH-1:0]            drop_count,
    output logic                            overflow,
    output logic                            any_report
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic [TS_WIDTH-1:0]    sym_q, sym_d;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]       level_q, level_d;
    logic [NUM_REPORTS-1:0] vec_mem_q [FIFO_DEPTH];
    logic [NUM_REPORTS-1:0] vec_mem_d [FIFO_DEPTH];
    logic [TS_WIDTH-1:0]    ts_mem_q  [FIFO_DEPTH];
    logic [TS_WIDTH-1:0]    ts_mem_d  [FIFO_DEPTH];
    logic [NUM_REPORTS-1:0] sticky_q, sticky_d;
    logic [CNT_WIDTH-1:0]   hit_q [NUM_REPORTS];
    logic [CNT_WIDTH-1:0]   hit_d [NUM_REPORTS];
    logic [CNT_WIDTH-1:0]   drop_q, drop_d;
    logic                   ovf_q, ovf_d;
    logic                   any_q, any_d;

    logic ev;
    logic pop;
    logic push;
    logic drop;

    assign ev   = run && (report_in != '0);
    assign pop  = (level_q != '0) && ev_ready;
    // A full FIFO still accepts the event when the head leaves this cycle.
    assign push = ev && ((level_q != FULL_LVL) || pop);
    assign drop = ev && !push;

    always_comb begin
        sym_d     = sym_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        level_d   = level_q;
        vec_mem_d = vec_mem_q;
        ts_mem_d  = ts_mem_q;
        sticky_d  = sticky_q;
        hit_d     = hit_q;
        drop_d    = drop_q;
        ovf_d     = ovf_q;
        any_d     = 1'b0;
        if (clear) begin
            sym_d    = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            sticky_d = '0;
            drop_d   = '0;
            ovf_d    = 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                vec_mem_d[i] = '0;
                ts_mem_d[i]  = '0;
            end
            for (int i = 0; i < NUM_REPORTS; i++) begin
                hit_d[i] = '0;
            end
        end else begin
            if (run) begin
                sym_d = sym_q + TS_WIDTH'(1);
            end
            if (ev) begin
                any_d    = 1'b1;
                sticky_d = sticky_q | report_in;
                for (int i = 0; i < NUM_REPORTS; i++) begin
                    if (report_in[i] && (hit_q[i] != CNT_MAX)) begin
                        hit_d[i] = hit_q[i] + CNT_WIDTH'(1);
                    end
                end
            end
            if (push) begin
                vec_mem_d[wr_ptr_q] = report_in;
                ts_mem_d[wr_ptr_q]  = sym_q;
                wr_ptr_d            = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            level_d = level_q + LVL_W'(push) - LVL_W'(pop);
            if (drop) begin
                ovf_d = 1'b1;
                if (drop_q != CNT_MAX) begin
                    drop_d = drop_q + CNT_WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sym_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            sticky_q <= '0;
            drop_q   <= '0;
            ovf_q    <= 1'b0;
            any_q    <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                vec_mem_q[i] <= '0;
                ts_mem_q[i]  <= '0;
            end
            for (int i = 0; i < NUM_REPORTS; i++) begin
                hit_q[i] <= '0;
            end
        end else begin
            sym_q     <= sym_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            vec_mem_q <= vec_mem_d;
            ts_mem_q  <= ts_mem_d;
            sticky_q  <= sticky_d;
            hit_q     <= hit_d;
            drop_q    <= drop_d;
            ovf_q     <= ovf_d;
            any_q     <= any_d;
        end
    end

    assign ev_valid     = (level_q != '0);
    assign ev_vector    = vec_mem_q[rd_ptr_q];
    assign ev_timestamp = ts_mem_q[rd_ptr_q];
    assign fifo_level   = level_q;
    assign sticky_flags = sticky_q;
    assign drop_count   = drop_q;
    assign overflow     = ovf_q;
    assign any_report   = any_q;

    for (genvar g = 0; g < NUM_REPORTS; g++) begin : g_hit
        assign hit_count[g*CNT_WIDTH +: CNT_WIDTH] = hit_q[g];
    end

endmodule
